uart_frac_baud_gen: RTL and testbench
=====================================

Name: uart_frac_baud_gen

Overview:
Next-generation UART baud generator with a fractional divisor, a runtime-selectable oversampling ratio, a mid-bit sample strobe and a receiver phase-resync input. Divisor and ratio changes are double-buffered and take effect only on a bit boundary, so reprogramming never truncates a bit. It feeds the TX shifter (baud_tick) and the RX sampler (os_tick, mid_tick) of the UART core.

Parameters:
DIV_W, 16, width of the integer divisor (system clocks per oversample period)
FRAC_W, 4, width of the fractional divisor; fraction = div_frac / 2^FRAC_W
OSR_W, 5, width of the oversample-ratio field
RST_DIV, 326, integer divisor loaded at reset (50 MHz, 9600 baud, x16)
RST_FRAC, 0, fractional divisor loaded at reset
RST_OSR, 16, oversample ratio loaded at reset

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  generator run; low = counters held cleared
div_int  in  DIV_W  requested integer divisor; legal range >= 2
div_frac  in  FRAC_W  requested fractional divisor
osr  in  OSR_W  requested oversample ratio; legal range 4..2^OSR_W-1
cfg_load  in  1  one-cycle pulse; captures div_int, div_frac, osr into the pending set
rx_resync  in  1  one-cycle pulse; restarts bit phase (RX start-bit edge)
os_tick  out  1  one-cycle oversample strobe
mid_tick  out  1  one-cycle strobe at the middle oversample of each bit
baud_tick  out  1  one-cycle strobe at the end of each bit
cfg_pending  out  1  pending configuration not yet applied
cfg_err  out  1  sticky flag: last cfg_load was illegal and was discarded

Behaviour:
- Reset state: active set = RST_DIV/RST_FRAC/RST_OSR; cnt=0, os_cnt=0, acc=0, ext=0. All outputs 0.
- All outputs are registered. Ticks are high for exactly one clk.
- Divider: cnt increments on every clk with enable=1. Period P = div_int_act + ext. When cnt==P-1: next edge sets cnt<=0, os_tick<=1, and {ext,acc} <= acc + div_frac_act (FRAC_W+1-bit sum; ext = carry). Otherwise os_tick<=0.
- Long-term os_tick period = div_int + div_frac/2^FRAC_W clocks. Individual periods are div_int or div_int+1.
- The first os_tick occurs P clocks after the first enabled edge.
- Oversample counter: os_cnt increments on each os_tick and wraps at osr_act.
  - mid_tick is asserted with the os_tick that makes os_cnt reach floor(osr_act/2).
  - baud_tick is asserted with the os_tick that makes os_cnt wrap, i.e. the osr_act-th os_tick.
- cfg_load:
  - If div_int<2 or osr<4: cfg_err<=1, the pending set is unchanged, and cfg_pending is unchanged.
  - Otherwise: capture into the pending set, cfg_pending<=1, cfg_err<=0.
  - A later legal cfg_load before application overwrites the pending set.
- Application of the pending set: in the same edge that asserts baud_tick, the active set <= pending set, acc<=0, ext<=0, cfg_pending<=0. The new timing starts with the next bit.
- If enable=0, or rx_resync=1 while cfg_pending=1, the pending set is applied immediately.
- cfg_load coincident with an application edge: the application uses the old pending set. The new capture is stored and remains pending.
- rx_resync: next edge sets cnt, os_cnt, acc and ext to 0 and forces all ticks to 0. The following os_tick is a full P later. rx_resync overrides a tick that would have fired in the same cycle.
- enable=0: cnt, os_cnt, acc and ext are held at 0 and all ticks are 0. cfg_load is still accepted. Re-enabling behaves exactly as after reset with the active set.
- Reset mid-operation restores the reset state and discards the pending set.

Test Plan:
- Reset then enable; load div_int=4, frac=0, osr=16 with enable=0 -> os_tick every 4 clks, first 4 clks after enable; mid_tick on the 8th os_tick (clk 32); baud_tick on the 16th os_tick (clk 64); then every 64 clks.
- Load div_int=4, div_frac=8, osr=4 -> os_tick intervals 4,4,5,4,5,...; 256 os_ticks span exactly 1152 clks ±4.
- While running at div 4/osr 4, legal cfg_load to div_int=6 mid-bit -> cfg_pending=1; current bit still ends after 16 clks; next bit lasts 24 clks; cfg_pending=0 at that baud_tick.
- cfg_load with div_int=1, then with osr=3 -> cfg_err=1 each time, timing unchanged; following legal load -> cfg_err=0.
- rx_resync asserted 2 clks before an expected os_tick -> no tick in that cycle; next os_tick exactly P clks after the resync edge; mid_tick at 2×P clks for osr=4.
- Assert reset mid-bit with cfg_pending=1 -> all outputs 0 immediately; after release, timing uses RST_DIV=326 and RST_OSR=16 (first baud_tick 5216 clks after enable).

Source files
------------

// File: rtl/uart_frac_baud_gen.sv
// Fractional-divisor UART baud generator: oversample, mid-bit and end-of-bit strobes.
// Divisor/ratio reprogramming is double-buffered and applied only on a bit boundary.
module uart_frac_baud_gen #(
  parameter int DIV_W    = 16,
  parameter int FRAC_W   = 4,
  parameter int OSR_W    = 5,
  parameter int RST_DIV  = 326,
  parameter int RST_FRAC = 0,
  parameter int RST_OSR  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DIV_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic [OSR_W-1:0]  osr,
  input  logic              cfg_load,
  input  logic              rx_resync,
  output logic              os_tick,
  output logic              mid_tick,
  output logic              baud_tick,
  output logic              cfg_pending,
  output logic              cfg_err
);

  logic [DIV_W-1:0]  div_int_act, div_int_pnd;
  logic [FRAC_W-1:0] div_frac_act, div_frac_pnd;
  logic [OSR_W-1:0]  osr_act, osr_pnd;

  logic [DIV_W-1:0]  cnt;
  logic [OSR_W-1:0]  os_cnt;
  logic [FRAC_W-1:0] acc;
  logic              ext;

  logic [DIV_W:0]    period_m1;
  logic              at_end;
  logic [OSR_W-1:0]  os_cnt_inc;
  logic              bit_end;
  logic              cfg_legal;
  logic              apply;
  logic [FRAC_W:0]   acc_sum;

  // Current period is div_int_act, stretched by one clock when the fraction carried.
  assign period_m1  = {1'b0, div_int_act} + {{DIV_W{1'b0}}, ext} - (DIV_W+1)'(1);
  assign at_end     = ({1'b0, cnt} == period_m1);
  assign os_cnt_inc = os_cnt + OSR_W'(1);
  assign bit_end    = enable && !rx_resync && at_end && (os_cnt_inc == osr_act);
  assign cfg_legal  = (div_int >= DIV_W'(2)) && (osr >= OSR_W'(4));
  assign apply      = cfg_pending && (!enable || rx_resync || bit_end);
  assign acc_sum    = {1'b0, acc} + {1'b0, div_frac_act};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_int_act  <= DIV_W'(RST_DIV);
      div_frac_act <= FRAC_W'(RST_FRAC);
      osr_act      <= OSR_W'(RST_OSR);
      div_int_pnd  <= DIV_W'(RST_DIV);
      div_frac_pnd <= FRAC_W'(RST_FRAC);
      osr_pnd      <= OSR_W'(RST_OSR);
      cnt          <= '0;
      os_cnt       <= '0;
      acc          <= '0;
      ext          <= 1'b0;
      os_tick      <= 1'b0;
      mid_tick     <= 1'b0;
      baud_tick    <= 1'b0;
      cfg_pending  <= 1'b0;
      cfg_err      <= 1'b0;
    end else begin
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      baud_tick <= 1'b0;

      if (!enable || rx_resync) begin
        cnt    <= '0;
        os_cnt <= '0;
        acc    <= '0;
        ext    <= 1'b0;
      end else if (at_end) begin
        cnt        <= '0;
        os_tick    <= 1'b1;
        {ext, acc} <= acc_sum;
        if (os_cnt_inc == osr_act) begin
          os_cnt    <= '0;
          baud_tick <= 1'b1;
        end else begin
          os_cnt   <= os_cnt_inc;
          mid_tick <= (os_cnt_inc == (osr_act >> 1));
        end
      end else begin
        cnt <= cnt + DIV_W'(1);
      end

      // Applying restarts the fraction so the new bit begins phase-clean.
      if (apply) begin
        div_int_act  <= div_int_pnd;
        div_frac_act <= div_frac_pnd;
        osr_act      <= osr_pnd;
        acc          <= '0;
        ext          <= 1'b0;
        cfg_pending  <= 1'b0;
      end

      // A capture on the application edge stays pending (last assignment wins).
      if (cfg_load) begin
        if (cfg_legal) begin
          div_int_pnd  <= div_int;
          div_frac_pnd <= div_frac;
          osr_pnd      <= osr;
          cfg_pending  <= 1'b1;
          cfg_err      <= 1'b0;
        end else begin
          cfg_err <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_frac_baud_gen.sv
// Directed bench for uart_frac_baud_gen: tick-count vector table plus
// hand-written sequences for reprogramming, illegal loads, resync and reset.
module tb_uart_frac_baud_gen;

  localparam int DIV_W  = 16;
  localparam int FRAC_W = 4;
  localparam int OSR_W  = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic [OSR_W-1:0]  osr;
  logic              cfg_load;
  logic              rx_resync;
  logic              os_tick;
  logic              mid_tick;
  logic              baud_tick;
  logic              cfg_pending;
  logic              cfg_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    int div_i;
    int frac;
    int osr_v;
    int n_clk;
    int exp_first;
    int exp_os;
    int exp_mid;
    int exp_baud;
  } vec_t;

  vec_t vecs[4];

  uart_frac_baud_gen #(
    .DIV_W(DIV_W), .FRAC_W(FRAC_W), .OSR_W(OSR_W),
    .RST_DIV(326), .RST_FRAC(0), .RST_OSR(16)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .div_int(div_int), .div_frac(div_frac), .osr(osr),
    .cfg_load(cfg_load), .rx_resync(rx_resync),
    .os_tick(os_tick), .mid_tick(mid_tick), .baud_tick(baud_tick),
    .cfg_pending(cfg_pending), .cfg_err(cfg_err)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Driver tasks: outputs sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic load(input int d, input int f, input int o);
    div_int  = DIV_W'(d);
    div_frac = FRAC_W'(f);
    osr      = OSR_W'(o);
    cfg_load = 1'b1;
    step();
    cfg_load = 1'b0;
  endtask

  task automatic setup_cfg(input int d, input int f, input int o);
    enable    = 1'b0;
    rx_resync = 1'b0;
    load(d, f, o);
    step();
    step();
    check("setup_pending_cleared", int'(cfg_pending), 0);
    enable = 1'b1;
    cyc    = 0;
  endtask

  // which: 0 = os_tick, 1 = mid_tick, 2 = baud_tick; at = -1 if the budget expires.
  task automatic wait_tick(input int which, input int limit, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if ((which == 0 && os_tick) || (which == 1 && mid_tick) || (which == 2 && baud_tick)) begin
        at = cyc;
        break;
      end
    end
  endtask

  initial begin
    int at;
    int first, n_os, n_mid, n_baud;

    vecs[0] = '{div_i: 4, frac: 0,  osr_v: 16, n_clk: 128,  exp_first: 4, exp_os: 32,  exp_mid: 2,  exp_baud: 2};
    vecs[1] = '{div_i: 4, frac: 8,  osr_v: 4,  n_clk: 1152, exp_first: 4, exp_os: 256, exp_mid: 64, exp_baud: 64};
    vecs[2] = '{div_i: 3, frac: 4,  osr_v: 5,  n_clk: 130,  exp_first: 3, exp_os: 40,  exp_mid: 8,  exp_baud: 8};
    vecs[3] = '{div_i: 2, frac: 15, osr_v: 31, n_clk: 96,   exp_first: 2, exp_os: 33,  exp_mid: 1,  exp_baud: 1};

    reset     = 1'b1;
    enable    = 1'b0;
    cfg_load  = 1'b0;
    rx_resync = 1'b0;
    div_int   = '0;
    div_frac  = '0;
    osr       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_os_tick", int'(os_tick), 0);
    check("rst_mid_tick", int'(mid_tick), 0);
    check("rst_baud_tick", int'(baud_tick), 0);
    check("rst_cfg_pending", int'(cfg_pending), 0);
    check("rst_cfg_err", int'(cfg_err), 0);
    reset = 1'b0;
    step();

    // Table-driven tick counting
    foreach (vecs[i]) begin
      setup_cfg(vecs[i].div_i, vecs[i].frac, vecs[i].osr_v);
      first = -1; n_os = 0; n_mid = 0; n_baud = 0;
      for (int c = 1; c <= vecs[i].n_clk; c++) begin
        step();
        if (os_tick) begin
          n_os++;
          if (first < 0) first = cyc;
        end
        if (mid_tick)  n_mid++;
        if (baud_tick) n_baud++;
      end
      check($sformatf("v%0d_first_os", i), first, vecs[i].exp_first);
      check($sformatf("v%0d_os_count", i), n_os, vecs[i].exp_os);
      check($sformatf("v%0d_mid_count", i), n_mid, vecs[i].exp_mid);
      check($sformatf("v%0d_baud_count", i), n_baud, vecs[i].exp_baud);
      enable = 1'b0;
      step();
    end

    // Mid-bit reprogram: current 16-clk bit finishes, next bit is 24 clks
    setup_cfg(4, 0, 4);
    repeat (5) step();
    load(6, 0, 4);
    check("reprog_pending_set", int'(cfg_pending), 1);
    wait_tick(2, 100, at);
    check("reprog_old_bit_end", at, 16);
    check("reprog_pending_clear", int'(cfg_pending), 0);
    wait_tick(2, 100, at);
    check("reprog_new_bit_end", at, 40);

    // Illegal loads are flagged and discarded
    load(1, 0, 4);
    check("illegal_div_err", int'(cfg_err), 1);
    check("illegal_div_no_pending", int'(cfg_pending), 0);
    load(6, 0, 3);
    check("illegal_osr_err", int'(cfg_err), 1);
    wait_tick(2, 100, at);
    check("illegal_timing_kept", at, 64);
    load(5, 0, 4);
    check("legal_clears_err", int'(cfg_err), 0);
    check("legal_sets_pending", int'(cfg_pending), 1);
    wait_tick(2, 100, at);
    check("legal_old_bit_end", at, 88);
    wait_tick(2, 100, at);
    check("legal_new_bit_end", at, 108);

    // rx_resync two clocks before an expected os_tick, then coincident with one
    setup_cfg(4, 0, 4);
    repeat (5) step();
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    step();
    step();
    check("resync_no_tick_at_8", int'(os_tick), 0);
    wait_tick(0, 20, at);
    check("resync_next_os", at, 10);
    wait_tick(1, 20, at);
    check("resync_mid", at, 14);
    repeat (3) step();
    rx_resync = 1'b1;
    step();
    rx_resync = 1'b0;
    check("resync_overrides_tick", int'(os_tick), 0);
    wait_tick(0, 20, at);
    check("resync_override_next_os", at, 22);

    // Asynchronous reset mid-bit discards pending config
    setup_cfg(4, 0, 4);
    repeat (5) step();
    load(6, 0, 4);
    check("rst2_pending_before", int'(cfg_pending), 1);
    #2;
    reset  = 1'b1;
    enable = 1'b0;
    #1;
    check("rst2_pending_async", int'(cfg_pending), 0);
    check("rst2_os_async", int'(os_tick), 0);
    check("rst2_baud_async", int'(baud_tick), 0);
    @(posedge clk);
    #3;
    reset = 1'b0;
    step();
    enable = 1'b1;
    cyc    = 0;
    wait_tick(0, 400, at);
    check("rst2_first_os", at, 326);
    wait_tick(1, 3000, at);
    check("rst2_first_mid", at, 2608);
    wait_tick(2, 3000, at);
    check("rst2_first_baud", at, 5216);
    check("rst2_no_pending", int'(cfg_pending), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
